// File: rtl/mem_region_decoder.sv
// Even/odd-lane region decoder with pipelined read-return mux and sticky decode error.
// Optional write protection via MEM_REGION_DECODER_WRITE_PROTECT_EN.
module mem_region_decoder #(
    parameter int REGIONS = 3,
    parameter int ADDRBITS = 15,
    parameter int DATABITS = 8,
    parameter logic [REGIONS*ADDRBITS-1:0] REGION_BASE = {15'h1000, 15'h0800, 15'h0000},
    parameter logic [REGIONS*ADDRBITS-1:0] REGION_TOP = {15'h2000, 15'h1000, 15'h0010},
    parameter int READ_LATENCY = 1,
    parameter logic [DATABITS-1:0] READ_FILL = 8'hFF,
    parameter logic [REGIONS-1:0] RO_MASK = 3'b010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRBITS-1:0]          read_addr_even,
    input  logic [ADDRBITS-1:0]          read_addr_odd,
    input  logic [ADDRBITS-1:0]          write_addr_even,
    input  logic [ADDRBITS-1:0]          write_addr_odd,
    input  logic                         write_en_even,
    input  logic                         write_en_odd,
    output logic [REGIONS-1:0]           region_write_en_even,
    output logic [REGIONS-1:0]           region_write_en_odd,
    input  logic [REGIONS*DATABITS-1:0]  region_read_data_even,
    input  logic [REGIONS*DATABITS-1:0]  region_read_data_odd,
    output logic [DATABITS-1:0]          read_data_even,
    output logic [DATABITS-1:0]          read_data_odd,
    input  logic                         err_clear,
    output logic                         err,
    output logic [ADDRBITS-1:0]          err_addr,
    output logic                         err_is_write,
    output logic                         err_odd
);

`ifdef MEM_REGION_DECODER_WRITE_PROTECT_EN
    localparam logic [REGIONS-1:0] W_RO = RO_MASK;
`else
    localparam logic [REGIONS-1:0] W_RO = RO_MASK & {REGIONS{1'b0}};
`endif

    // One-hot hit vector, lowest index wins; all-zero means unmapped.
    function automatic logic [REGIONS-1:0] f_decode(input logic [ADDRBITS-1:0] a);
        f_decode = '0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (a >= REGION_BASE[i*ADDRBITS +: ADDRBITS] &&
                a < REGION_TOP[i*ADDRBITS +: ADDRBITS]) begin
                f_decode = '0;
                f_decode[i] = 1'b1;
            end
        end
    endfunction

    function automatic logic [DATABITS-1:0] f_mux(
        input logic [REGIONS-1:0] sel,
        input logic [REGIONS*DATABITS-1:0] data
    );
        f_mux = '0;
        if (sel == '0) begin
            f_mux = READ_FILL;
        end else begin
            for (int i = 0; i < REGIONS; i++) begin
                if (sel[i]) f_mux = f_mux | data[i*DATABITS +: DATABITS];
            end
        end
    endfunction

    logic [REGIONS-1:0] w_rhit_e, w_rhit_o, w_wok_e, w_wok_o;
    logic               w_wf_e, w_wf_o, w_rf_e, w_rf_o;
    logic               w_fault, w_fw, w_fodd;
    logic [ADDRBITS-1:0] w_faddr;
    logic [REGIONS-1:0] r_sel_e [READ_LATENCY];
    logic [REGIONS-1:0] r_sel_o [READ_LATENCY];

    assign w_rhit_e = f_decode(read_addr_even);
    assign w_rhit_o = f_decode(read_addr_odd);
    assign w_wok_e  = f_decode(write_addr_even) & ~W_RO;
    assign w_wok_o  = f_decode(write_addr_odd) & ~W_RO;
    assign w_wf_e   = write_en_even && (w_wok_e == '0);
    assign w_wf_o   = write_en_odd && (w_wok_o == '0);
    assign w_rf_e   = (w_rhit_e == '0);
    assign w_rf_o   = (w_rhit_o == '0);

    assign region_write_en_even = (write_en_even && !reset) ? w_wok_e : '0;
    assign region_write_en_odd  = (write_en_odd && !reset) ? w_wok_o : '0;

    assign read_data_even = f_mux(r_sel_e[READ_LATENCY-1], region_read_data_even);
    assign read_data_odd  = f_mux(r_sel_o[READ_LATENCY-1], region_read_data_odd);

    // Simultaneous faults: even write, even read, odd write, odd read.
    always_comb begin
        w_fault = 1'b1;
        w_faddr = '0;
        w_fw    = 1'b0;
        w_fodd  = 1'b0;
        if (w_wf_e) begin
            w_faddr = write_addr_even;
            w_fw    = 1'b1;
        end else if (w_rf_e) begin
            w_faddr = read_addr_even;
        end else if (w_wf_o) begin
            w_faddr = write_addr_odd;
            w_fw    = 1'b1;
            w_fodd  = 1'b1;
        end else if (w_rf_o) begin
            w_faddr = read_addr_odd;
            w_fodd  = 1'b1;
        end else begin
            w_fault = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_sel_e[i] <= '0;
                r_sel_o[i] <= '0;
            end
        end else begin
            r_sel_e[0] <= w_rhit_e;
            r_sel_o[0] <= w_rhit_o;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_sel_e[i] <= r_sel_e[i-1];
                r_sel_o[i] <= r_sel_o[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err          <= 1'b0;
            err_addr     <= '0;
            err_is_write <= 1'b0;
            err_odd      <= 1'b0;
        end else if (w_fault && (!err || err_clear)) begin
            err          <= 1'b1;
            err_addr     <= w_faddr;
            err_is_write <= w_fw;
            err_odd      <= w_fodd;
        end else if (err_clear) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_region_decoder.sv
// Randomised and directed checks of mem_region_decoder at read latency 1 and 3
// against a queue/list based reference model.
module tb_mem_region_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rae, rao, wae, wao;
    logic        wee, weo, clr;
    logic [23:0] rde, rdo;

    logic [2:0]  se1, so1, se3, so3;
    logic [7:0]  de1, do1, de3, do3;
    logic        er1, ew1, eo1, er3, ew3, eo3;
    logic [14:0] ea1, ea3;

    int total = 0;
    int bad = 0;

    int BASE[3] = '{'h0000, 'h0800, 'h1000};
    int TOP[3]  = '{'h0010, 'h1000, 'h2000};
    bit RO[3]   = '{0, 1, 0};
`ifdef MEM_REGION_DECODER_WRITE_PROTECT_EN
    bit WP = 1;
`else
    bit WP = 0;
`endif

    int q_e1[$], q_o1[$], q_e3[$], q_o3[$];
    bit        m_err, m_w, m_odd;
    int        m_addr;

    always #5 clk = ~clk;

    mem_region_decoder #(.READ_LATENCY(1)) u1 (
        .clk(clk), .reset(rst),
        .read_addr_even(rae), .read_addr_odd(rao),
        .write_addr_even(wae), .write_addr_odd(wao),
        .write_en_even(wee), .write_en_odd(weo),
        .region_write_en_even(se1), .region_write_en_odd(so1),
        .region_read_data_even(rde), .region_read_data_odd(rdo),
        .read_data_even(de1), .read_data_odd(do1),
        .err_clear(clr), .err(er1), .err_addr(ea1),
        .err_is_write(ew1), .err_odd(eo1)
    );

    mem_region_decoder #(.READ_LATENCY(3)) u3 (
        .clk(clk), .reset(rst),
        .read_addr_even(rae), .read_addr_odd(rao),
        .write_addr_even(wae), .write_addr_odd(wao),
        .write_en_even(wee), .write_en_odd(weo),
        .region_write_en_even(se3), .region_write_en_odd(so3),
        .region_read_data_even(rde), .region_read_data_odd(rdo),
        .read_data_even(de3), .read_data_odd(do3),
        .err_clear(clr), .err(er3), .err_addr(ea3),
        .err_is_write(ew3), .err_odd(eo3)
    );

    function automatic int ref_dec(int a);
        for (int i = 0; i < 3; i++)
            if (a >= BASE[i] && a < TOP[i]) return i;
        return -1;
    endfunction

    function automatic bit wr_ok(int a);
        int d = ref_dec(a);
        return d >= 0 && !(WP && RO[d]);
    endfunction

    function automatic logic [2:0] exp_strobe(logic we, int a);
        logic [2:0] s = 3'b000;
        if (!rst && we && wr_ok(a)) s[ref_dec(a)] = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] exp_rd(int idx, logic [23:0] d);
        logic [23:0] t = d;
        if (idx < 0) return 8'hFF;
        return t[idx*8 +: 8];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_e1 = '{-1}; q_o1 = '{-1};
        q_e3 = '{-1, -1, -1}; q_o3 = '{-1, -1, -1};
        m_err = 0; m_addr = 0; m_w = 0; m_odd = 0;
    endtask

    task automatic model_advance();
        int fa[$];
        bit fw[$], fo[$];
        if (rst) begin
            model_reset();
            return;
        end
        if (wee && !wr_ok(int'(wae))) begin fa.push_back(int'(wae)); fw.push_back(1); fo.push_back(0); end
        if (ref_dec(int'(rae)) < 0)    begin fa.push_back(int'(rae)); fw.push_back(0); fo.push_back(0); end
        if (weo && !wr_ok(int'(wao))) begin fa.push_back(int'(wao)); fw.push_back(1); fo.push_back(1); end
        if (ref_dec(int'(rao)) < 0)    begin fa.push_back(int'(rao)); fw.push_back(0); fo.push_back(1); end
        if (fa.size() > 0 && (!m_err || clr)) begin
            m_err = 1; m_addr = fa[0]; m_w = fw[0]; m_odd = fo[0];
        end else if (clr) begin
            m_err = 0;
        end
        q_e1.push_back(ref_dec(int'(rae))); void'(q_e1.pop_front());
        q_o1.push_back(ref_dec(int'(rao))); void'(q_o1.pop_front());
        q_e3.push_back(ref_dec(int'(rae))); void'(q_e3.pop_front());
        q_o3.push_back(ref_dec(int'(rao))); void'(q_o3.pop_front());
    endtask

    task automatic check_all();
        chk("l1.rd_even", 32'(de1), 32'(exp_rd(q_e1[0], rde)));
        chk("l1.rd_odd",  32'(do1), 32'(exp_rd(q_o1[0], rdo)));
        chk("l3.rd_even", 32'(de3), 32'(exp_rd(q_e3[0], rde)));
        chk("l3.rd_odd",  32'(do3), 32'(exp_rd(q_o3[0], rdo)));
        chk("l1.wen_even", 32'(se1), 32'(exp_strobe(wee, int'(wae))));
        chk("l1.wen_odd",  32'(so1), 32'(exp_strobe(weo, int'(wao))));
        chk("l3.wen_even", 32'(se3), 32'(exp_strobe(wee, int'(wae))));
        chk("l3.wen_odd",  32'(so3), 32'(exp_strobe(weo, int'(wao))));
        chk("l1.err", 32'(er1), 32'(m_err));
        chk("l3.err", 32'(er3), 32'(m_err));
        chk("l1.err_addr", 32'(ea1), 32'(m_addr));
        chk("l3.err_addr", 32'(ea3), 32'(m_addr));
        chk("l1.err_is_write", 32'(ew1), 32'(m_w));
        chk("l1.err_odd", 32'(eo1), 32'(m_odd));
        chk("l3.err_is_write", 32'(ew3), 32'(m_w));
        chk("l3.err_odd", 32'(eo3), 32'(m_odd));
    endtask

    task automatic tick();
        #1;
        check_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] pick_addr();
        logic [14:0] pool[10] = '{15'h0000, 15'h000F, 15'h0010, 15'h07FF, 15'h0800,
                                  15'h0FFF, 15'h1000, 15'h1FFF, 15'h2000, 15'h7FFF};
        case ($urandom_range(0, 3))
            0: return pool[$urandom_range(0, 9)];
            1: return 15'($urandom_range(0, 'h7FFF));
            default: return 15'($urandom_range('h0800, 'h1FFF));
        endcase
    endfunction

    initial begin
        rst = 1; rae = 15'h0805; rao = 15'h0001; wae = 0; wao = 0;
        wee = 0; weo = 0; clr = 0; rde = 24'h00A5_00; rdo = 24'h123456;
        model_reset();
        @(posedge clk); #1;
        tick();
        tick();
        rst = 0;
        // first read after reset: fill, then region 1 data
        tick();
        tick();
        wao = 15'h1234; weo = 1;
        tick();
        weo = 0; rao = 15'h0020;
        tick();
        rao = 15'h0001;
        tick();
        rao = 15'h3000;
        tick();
        rao = 15'h0001;
        tick();
        clr = 1;
        tick();
        clr = 0;
        tick();
        wae = 15'h0400; wee = 1; rao = 15'h7FFF;
        tick();
        wee = 0; rao = 15'h0001;
        tick();
        clr = 1;
        tick();
        clr = 0;
        tick();
        clr = 1; rae = 15'h0011;
        tick();
        clr = 0; rae = 15'h0805;
        tick();
        clr = 1;
        tick();
        clr = 0;
        wae = 15'h0900; wee = 1;
        tick();
        wee = 0;
        tick();
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 10; i++) begin
            rae = (i % 2 == 0) ? 15'h0000 : 15'h1000;
            rde = 24'($urandom);
            tick();
        end
        // reset mid-stream, read data must fall back to fill at once
        rst = 1; wee = 1; wae = 15'h1100;
        model_reset();
        tick();
        tick();
        rst = 0; wee = 0;
        for (int i = 0; i < 6; i++) begin
            rae = (i % 2 == 0) ? 15'h1000 : 15'h0000;
            rde = 24'($urandom);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            rae = pick_addr(); rao = pick_addr();
            wae = pick_addr(); wao = pick_addr();
            wee = 1'($urandom_range(0, 1));
            weo = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 5) == 0);
            rde = 24'($urandom); rdo = 24'($urandom);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
